// File: rtl/divmod_wb_buffer_pkg.sv
// Shared definitions for the divider writeback buffer: default sizes,
// divider op codes and the layout of one buffered writeback entry.
package divmod_wb_buffer_pkg;

    localparam int WB_DEPTH  = 4;
    localparam int WB_DATA_W = 32;
    localparam int WB_TAG_W  = 6;

    // Divider configuration codes used by the issue side.
    typedef enum logic [1:0] {
        DIVMOD_DIV  = 2'd0,
        DIVMOD_DIVU = 2'd1,
        DIVMOD_REM  = 2'd2,
        DIVMOD_REMU = 2'd3
    } divmod_op_e;

    // One writeback entry. The FIFO stores entries packed in exactly this
    // field order (MSB first), so the flat vector and the struct agree.
    typedef struct packed {
        logic [WB_DATA_W-1:0] Result;
        logic [WB_TAG_W-1:0]  Pd;
        logic                 ready;
        logic                 RegWr;
        logic [WB_TAG_W-1:0]  tag_rob;
    } wb_entry_t;

    // Width of a packed entry for a given data/tag width.
    function automatic int entry_width(input int data_w, input int tag_w);
        return data_w + 2 * tag_w + 2;
    endfunction

endpackage

// File: rtl/divmod_wb_buffer_fifo.sv
// In-order FIFO of packed writeback entries with push/pop/flush.
// Push when full is only accepted together with a pop. Flush wins over
// push and pop in the same cycle.
module divmod_wb_buffer_fifo
    import divmod_wb_buffer_pkg::*;
#(
    parameter int DEPTH = WB_DEPTH,
    parameter int WIDTH = entry_width(WB_DATA_W, WB_TAG_W)
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       flush_i,
    input  logic                       push_i,
    input  logic                       pop_i,
    input  logic [WIDTH-1:0]           data_i,
    output logic [WIDTH-1:0]           data_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    // Pointers wrap modulo DEPTH, which need not be a power of two.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign data_o  = mem_q[rd_ptr_q];

    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);

    // Next pointer/count state; flush returns everything to empty.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = ptr_inc(wr_ptr_q);
            if (do_pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    // Control state register with asynchronous clear.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage; contents are only observable through a valid head.
    always_ff @(posedge clk_i) begin
        if (do_push && !flush_i) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

endmodule

// File: rtl/divmod_wb_buffer.sv
// Divider writeback buffer: captures divider results in completion order,
// offers the head to the writeback arbiter, and grants issue credit only
// while every in-flight op is guaranteed a buffer slot.
module divmod_wb_buffer
    import divmod_wb_buffer_pkg::*;
#(
    parameter int DEPTH  = WB_DEPTH,
    parameter int DATA_W = WB_DATA_W,
    parameter int TAG_W  = WB_TAG_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush_back,
    input  logic              issue_fire,
    output logic              issue_allow,
    input  logic              is_divmod,
    input  logic [DATA_W-1:0] Result_divmod,
    input  logic [TAG_W-1:0]  Pd_divmod,
    input  logic              ready_divmod,
    input  logic              RegWr_divmod,
    input  logic [TAG_W-1:0]  tag_rob_divmod,
    output logic              wb_valid,
    input  logic              wb_grant,
    output logic [DATA_W-1:0] wb_Result,
    output logic [TAG_W-1:0]  wb_Pd,
    output logic              wb_ready,
    output logic              wb_RegWr,
    output logic [TAG_W-1:0]  wb_tag_rob,
    output logic              ovf_err
);

    localparam int ENTRY_W = entry_width(DATA_W, TAG_W);
    localparam int INF_W   = $clog2(DEPTH + 1);
    localparam int SUM_W   = $clog2(2 * DEPTH + 1);

    logic [ENTRY_W-1:0] push_entry;
    logic [ENTRY_W-1:0] head_entry;
    logic               fifo_full, fifo_empty;
    logic [INF_W-1:0]   fifo_count;
    logic               pop, can_enq, push;
    logic [INF_W-1:0]   inflight_q, inflight_d;
    logic               ovf_err_q, ovf_err_d;

    assign push_entry = {Result_divmod, Pd_divmod, ready_divmod, RegWr_divmod, tag_rob_divmod};

    assign wb_valid = ~fifo_empty;
    assign pop      = wb_valid & wb_grant;
    assign can_enq  = ~fifo_full | pop;
    assign push     = is_divmod & can_enq;

    divmod_wb_buffer_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk_i   (clk),
        .rst_i   (rst),
        .flush_i (flush_back),
        .push_i  (push),
        .pop_i   (pop),
        .data_i  (push_entry),
        .data_o  (head_entry),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    // Head data is zero whenever there is no valid head.
    assign {wb_Result, wb_Pd, wb_ready, wb_RegWr, wb_tag_rob} = wb_valid ? head_entry : '0;

    // Credit from registered state only; a same-cycle dequeue is not counted.
    assign issue_allow = (SUM_W'(fifo_count) + SUM_W'(inflight_q)) < SUM_W'(DEPTH);

    assign ovf_err = ovf_err_q;

    // In-flight count: saturating at 0 and DEPTH, cleared by flush.
    always_comb begin
        inflight_d = inflight_q;
        if (flush_back) begin
            inflight_d = '0;
        end else if (issue_fire && !is_divmod) begin
            if (inflight_q != INF_W'(DEPTH)) inflight_d = inflight_q + 1'b1;
        end else if (!issue_fire && is_divmod) begin
            if (inflight_q != '0) inflight_d = inflight_q - 1'b1;
        end
    end

    // Sticky error: a dropped result or a result nobody issued.
    always_comb begin
        ovf_err_d = ovf_err_q;
        if (!flush_back && is_divmod && (!can_enq || inflight_q == '0)) begin
            ovf_err_d = 1'b1;
        end
    end

    // Control registers with asynchronous clear; flush leaves ovf_err alone.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inflight_q <= '0;
            ovf_err_q  <= 1'b0;
        end else begin
            inflight_q <= inflight_d;
            ovf_err_q  <= ovf_err_d;
        end
    end

endmodule
